// File: rtl/fas_serial_unit.sv
// Bit-serial N-bit add/sub around one fas cell, LSB first, result after N+1 edges.
// No backpressure: start is ignored while busy and accepted again in the done cycle.

module fas (
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic a_ns,
   output logic s,
   output logic cout
);
   logic ax;

   // Inverting a turns the majority carry into the subtract borrow.
   assign ax   = a_ns ? a : ~a;
   assign s    = a ^ b ^ cin;
   assign cout = (ax & b) | (ax & cin) | (b & cin);
endmodule

module fas_serial_unit #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         a_ns,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         cout
);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state_q,  state_d;
   logic [N-1:0]  a_sh_q,   a_sh_d;
   logic [N-1:0]  b_sh_q,   b_sh_d;
   logic [N-2:0]  sum_sh_q, sum_sh_d;
   logic          carry_q,  carry_d;
   logic          op_q,     op_d;
   logic [CW-1:0] cnt_q,    cnt_d;
   logic [N-1:0]  result_q, result_d;
   logic          cout_q,   cout_d;

   logic fas_s;
   logic fas_cout;

   fas u_fas (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .a_ns (op_q),
      .s    (fas_s),
      .cout (fas_cout)
   );

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      cout_d   = cout_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               op_d    = a_ns;
               carry_d = cin;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            a_sh_d   = {1'b0, a_sh_q[N-1:1]};
            b_sh_d   = {1'b0, b_sh_q[N-1:1]};
            // Upper N-1 sum bits only; the final bit goes straight into result.
            sum_sh_d = (N-1)'({fas_s, sum_sh_q} >> 1);
            carry_d  = fas_cout;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               result_d = {fas_s, sum_sh_q};
               cout_d   = fas_cout;
               state_d  = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         op_q     <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         cout_q   <= cout_d;
      end
   end

   assign busy   = (state_q == ST_RUN);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign cout   = cout_q;
endmodule

// File: tb/tb_fas_serial_unit.sv
// Scoreboard bench for fas_serial_unit: expectations queued at start, checked on done.

module tb_fas_serial_unit;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         a_ns;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         cout;

   int total = 0;
   int bad   = 0;
   int done_seen = 0;
   logic [N:0] exp_q[$];
   logic [N:0] mon_e;

   always #5 clk = ~clk;

   fas_serial_unit #(.N(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a_ns   (a_ns),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                        input logic c, input logic op);
      logic [N:0] r;
      if (op) begin
         r = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
      end else begin
         r[N-1:0] = x - y - {{(N-1){1'b0}}, c};
         r[N]     = ({1'b0, x} < ({1'b0, y} + {{N{1'b0}}, c}));
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst === 1'b1 && done === 1'b1) begin
         done_seen++;
         chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("result", 32'(result), 32'(mon_e[N-1:0]));
            chk("cout", 32'(cout), 32'(mon_e[N]));
         end
      end
   end

   task automatic start_op(input logic [N-1:0] xa, input logic [N-1:0] xb,
                           input logic xc, input logic op, input bit push);
      @(negedge clk);
      a = xa; b = xb; cin = xc; a_ns = op; start = 1'b1;
      @(posedge clk);
      if (push) exp_q.push_back(model(xa, xb, xc, op));
      #1 start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) return;
      end
      chk("done_timeout", 32'd0, 32'd1);
   endtask

   // Called right after the start edge; counts edges (start edge included) up to done.
   task automatic measure(output int lat, output int bcnt);
      lat  = 1;
      bcnt = busy ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) return;
         if (busy) bcnt++;
      end
   endtask

   initial begin
      int lat, bcnt, seen0;
      rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; a_ns = 1'b1;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Basic add with latency and busy length
      start_op(8'h5A, 8'h33, 1'b0, 1'b1, 1'b1);
      measure(lat, bcnt);
      chk("add_latency", 32'(lat), 32'd9);
      chk("add_busy_cycles", 32'(bcnt), 32'd8);
      chk("add_direct", 32'({cout, result}), 32'h08D);

      start_op(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1); wait_done();
      chk("wrap_direct", 32'({cout, result}), 32'h100);
      start_op(8'hFF, 8'h01, 1'b1, 1'b1, 1'b1); wait_done();
      chk("wrap_cin_direct", 32'({cout, result}), 32'h101);
      start_op(8'h33, 8'h5A, 1'b0, 1'b0, 1'b1); wait_done();
      chk("sub_borrow_direct", 32'({cout, result}), 32'h1D9);
      start_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b1); wait_done();
      chk("sub_cin_direct", 32'({cout, result}), 32'h07E);

      // start during RUN must be ignored
      start_op(8'h5A, 8'h33, 1'b0, 1'b1, 1'b1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      a = 8'hC3; b = 8'h77; cin = 1'b1; a_ns = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      seen0 = done_seen;
      wait_done();
      chk("run_start_ignored", 32'({cout, result}), 32'h08D);
      repeat (14) @(posedge clk);
      #1;
      chk("no_restart_dones", 32'(done_seen - seen0), 32'd1);

      // start issued in the DONE cycle starts a back-to-back op
      start_op(8'h10, 8'h20, 1'b0, 1'b1, 1'b1);
      wait_done();
      start_op(8'h12, 8'h34, 1'b0, 1'b1, 1'b1);
      measure(lat, bcnt);
      chk("b2b_latency", 32'(lat), 32'd9);
      chk("b2b_direct", 32'({cout, result}), 32'h046);

      // async reset between edges mid-RUN
      start_op(8'hAA, 8'h55, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_result", 32'(result), 32'd0);
      chk("arst_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      seen0 = done_seen;
      repeat (15) @(posedge clk);
      #1;
      chk("post_rst_dones", 32'(done_seen - seen0), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // random ops, checked by the scoreboard monitor
      for (int i = 0; i < 500; i++) begin
         start_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         wait_done();
      end
      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
